// File: rtl/ysyx_22051013_icache_axi_bridge.sv
// I-cache miss-refill bridge: turns a level refill request into one single-beat
// AXI4 read and returns the beat with a one-cycle valid pulse.
module ysyx_22051013_icache_axi_bridge #(
    parameter int          ADDR_W = 32,
    parameter int          ID_W   = 4,
    parameter int unsigned ARID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axi_ena,
    input  logic [63:0]       axi_pc,
    output logic [63:0]       axi_inst,
    output logic              axi_valid,
    output logic              rd_err,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [ID_W-1:0]   m_arid,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [2:0]        m_arprot,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [63:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic [ID_W-1:0]   m_rid,
    input  logic              m_rlast
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       inst_q, inst_d;
    logic              err_q, err_d;

    // Next-state and capture logic for the single outstanding transaction
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (axi_ena) begin
                    addr_d  = {axi_pc[ADDR_W-1:3], 3'b000};
                    state_d = S_AR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                if (m_arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (m_rvalid) begin
                    inst_d  = m_rdata;
                    // A missing RLAST on a single-beat burst is a protocol error too
                    err_d   = m_rresp[1] | ~m_rlast;
                    state_d = S_RESP;
                end else begin
                    state_d = S_R;
                end
            end
            S_RESP: state_d = S_DONE;
            S_DONE: begin
                // Wait for the request level to drop so a stale level cannot relaunch
                if (axi_ena) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, address and returned-beat registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            inst_q  <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign m_arvalid = (state_q == S_AR);
    assign m_rready  = (state_q == S_R);
    assign axi_valid = (state_q == S_RESP);
    assign axi_inst  = inst_q;
    assign rd_err    = err_q;
    assign m_araddr  = addr_q;
    assign m_arid    = ID_W'(ARID);
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b011;
    assign m_arburst = 2'b01;
    assign m_arprot  = 3'b100;

    logic unused_s;
    assign unused_s = ^{axi_pc[63:ADDR_W], axi_pc[2:0], m_rid, m_rresp[0]};

endmodule

// File: tb/tb_ysyx_22051013_icache_axi_bridge.sv
// Self-checking bench for the I-cache AXI refill bridge: directed scenarios plus
// randomized transactions checked against a transaction-level reference model.
module tb_ysyx_22051013_icache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_ena;
    logic [63:0] axi_pc;
    logic [63:0] axi_inst;
    logic        axi_valid;
    logic        rd_err;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [2:0]  m_arprot;
    logic        m_rvalid;
    logic        m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [3:0]  m_rid;
    logic        m_rlast;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int pulse_cnt = 0;

    ysyx_22051013_icache_axi_bridge #(.ADDR_W(32), .ID_W(4), .ARID(0)) dut (
        .clk(clk), .rst(rst), .axi_ena(axi_ena), .axi_pc(axi_pc),
        .axi_inst(axi_inst), .axi_valid(axi_valid), .rd_err(rd_err),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arprot(m_arprot), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rid(m_rid), .m_rlast(m_rlast)
    );

    always #5 clk = ~clk;

    // Bus monitor: counts AR handshakes and valid pulses
    always @(posedge clk) begin
        if (m_arvalid && m_arready) hs_cnt <= hs_cnt + 1;
        if (axi_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: aligned address and error flag of one transaction
    function automatic logic [31:0] ref_addr(input logic [63:0] pc);
        return pc[31:0] - (pc[31:0] % 32'd8);
    endfunction

    function automatic logic ref_err(input logic [1:0] resp, input logic last);
        return (resp == 2'b10) || (resp == 2'b11) || (last == 1'b0);
    endfunction

    // Acts as AXI slave for one read; returns what the DUT showed. Ends in the pulse cycle.
    task automatic do_read(input logic [63:0] pc, input logic [63:0] data,
                           input logic [1:0] resp, input logic last,
                           input int ar_dly, input int r_dly,
                           input logic early_r, input logic drop_ena,
                           output logic [31:0] addr_obs, output logic stable_ok,
                           output logic rready_ar, output logic rready_r,
                           output logic valid_obs, output logic [63:0] inst_obs,
                           output logic err_obs, output int lat, output logic timeout);
        stable_ok = 1'b1; rready_ar = 1'b0; rready_r = 1'b0;
        valid_obs = 1'b0; inst_obs = 64'd0; err_obs = 1'b0; timeout = 1'b0;
        axi_ena = 1'b1; axi_pc = pc; m_arready = 1'b0;
        lat = 0;
        while (!m_arvalid && lat < 20) begin
            tick();
            lat++;
        end
        if (!m_arvalid) begin
            timeout = 1'b1;
            return;
        end
        addr_obs = m_araddr;
        if (drop_ena) axi_ena = 1'b0;
        axi_pc = {$urandom, $urandom};
        for (int i = 0; i < ar_dly; i++) begin
            if (early_r) begin
                m_rvalid = 1'b1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                m_rresp = 2'b00; m_rlast = 1'b1;
            end
            if (m_rready) rready_ar = 1'b1;
            tick();
            if (!m_arvalid || m_araddr !== addr_obs) stable_ok = 1'b0;
        end
        m_rvalid = 1'b0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int i = 0; i < r_dly; i++) begin
            if (!m_rready) rready_r = 1'b0;
            tick();
        end
        rready_r = m_rready;
        m_rvalid = 1'b1; m_rdata = data; m_rresp = resp; m_rlast = last;
        tick();
        m_rvalid = 1'b0; m_rdata = 64'd0;
        valid_obs = axi_valid; inst_obs = axi_inst; err_obs = rd_err;
    endtask

    task automatic release_ena();
        axi_ena = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; axi_ena = 1'b0; axi_pc = 64'd0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rdata = 64'd0; m_rresp = 2'b00; m_rid = 4'd0; m_rlast = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({m_arvalid, m_rready, axi_valid, rd_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got %b want 0000", {m_arvalid, m_rready, axi_valid, rd_err});
        end
        total++;
        if (axi_inst !== 64'd0 || m_araddr !== 32'd0) begin
            bad++; $display("FAIL reset_regs: inst=%h addr=%h want 0", axi_inst, m_araddr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        int hs0;
        hs0 = hs_cnt;
        do_read(64'h8000_0014, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        total++;
        if (to !== 1'b0 || lat !== 1) begin bad++; $display("FAIL basic_lat: got %0d want 1", lat); end
        total++;
        if (a !== 32'h8000_0010) begin bad++; $display("FAIL basic_addr: got %h want 80000010", a); end
        total++;
        if ({m_arlen, m_arsize, m_arburst, m_arprot, m_arid} !== {8'd0, 3'b011, 2'b01, 3'b100, 4'd0}) begin
            bad++; $display("FAIL basic_const: len=%h size=%b burst=%b prot=%b id=%h", m_arlen, m_arsize, m_arburst, m_arprot, m_arid);
        end
        total++;
        if (v !== 1'b1 || d !== 64'h1234_5678_9ABC_DEF0 || e !== 1'b0 || rrr !== 1'b1) begin
            bad++; $display("FAIL basic_data: valid=%b inst=%h err=%b rready=%b want 1 123456789abcdef0 0 1", v, d, e, rrr);
        end
        axi_ena = 1'b0;
        tick();
        total++;
        if (axi_valid !== 1'b0 || axi_inst !== 64'h1234_5678_9ABC_DEF0) begin
            bad++; $display("FAIL basic_pulse: valid=%b inst=%h want 0 held", axi_valid, axi_inst);
        end
        tick();
        total++;
        if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL basic_hs: got %0d want 1", hs_cnt - hs0); end
    endtask

    task automatic test_ar_stall();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        int hs0;
        hs0 = hs_cnt;
        do_read(64'h0000_0000_4000_0A0F, 64'h5555_AAAA_0000_FFFF, 2'b00, 1'b1, 5, 1, 1'b1, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        total++;
        if (st !== 1'b1 || a !== 32'h4000_0A08) begin
            bad++; $display("FAIL stall_addr: stable=%b addr=%h want 1 40000a08", st, a);
        end
        total++;
        if (rra !== 1'b0) begin bad++; $display("FAIL stall_early_r: rready in AR=%b want 0", rra); end
        total++;
        if (v !== 1'b1 || d !== 64'h5555_AAAA_0000_FFFF) begin
            bad++; $display("FAIL stall_data: valid=%b inst=%h want 1 5555aaaa0000ffff", v, d);
        end
        release_ena();
        total++;
        if (hs_cnt - hs0 !== 1) begin bad++; $display("FAIL stall_hs: got %0d want 1", hs_cnt - hs0); end
    endtask

    task automatic test_error();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        do_read(64'h200, 64'hDEAD, 2'b10, 1'b1, 0, 2, 1'b0, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        total++;
        if (v !== 1'b1 || d !== 64'hDEAD || e !== 1'b1) begin
            bad++; $display("FAIL err_slverr: valid=%b inst=%h err=%b want 1 dead 1", v, d, e);
        end
        release_ena();
        total++;
        if (rd_err !== 1'b1) begin bad++; $display("FAIL err_hold: got %b want 1", rd_err); end
        do_read(64'h208, 64'h0BEE, 2'b00, 1'b1, 1, 0, 1'b0, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        total++;
        if (v !== 1'b1 || d !== 64'h0BEE || e !== 1'b0) begin
            bad++; $display("FAIL err_clear: valid=%b inst=%h err=%b want 1 bee 0", v, d, e);
        end
        release_ena();
    endtask

    task automatic test_done_hold();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        int hs0;
        logic seen;
        do_read(64'h300, 64'h77, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        hs0 = hs_cnt;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (m_arvalid || axi_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || hs_cnt !== hs0) begin
            bad++; $display("FAIL done_hold: activity=%b hs=%0d want 0 0", seen, hs_cnt - hs0);
        end
        axi_ena = 1'b0;
        tick();
        do_read(64'h310, 64'h88, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        total++;
        if (to !== 1'b0 || lat !== 1 || d !== 64'h88) begin
            bad++; $display("FAIL done_relaunch: lat=%0d inst=%h want 1 88", lat, d);
        end
        release_ena();
    endtask

    task automatic test_async_reset();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        axi_ena = 1'b1; axi_pc = 64'h400;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        total++;
        if (m_rready !== 1'b1) begin bad++; $display("FAIL arst_pre: rready=%b want 1", m_rready); end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({m_rready, m_arvalid, axi_valid} !== 3'b000 || axi_inst !== 64'd0) begin
            bad++; $display("FAIL arst_drop: ctl=%b inst=%h want 000 0", {m_rready, m_arvalid, axi_valid}, axi_inst);
        end
        #2 rst = 1'b0;
        axi_ena = 1'b0;
        tick();
        do_read(64'h408, 64'h99, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0,
                a, st, rra, rrr, v, d, e, lat, to);
        total++;
        if (to !== 1'b0 || lat !== 1 || v !== 1'b1 || d !== 64'h99) begin
            bad++; $display("FAIL arst_idle: lat=%0d valid=%b inst=%h want 1 1 99", lat, v, d);
        end
        release_ena();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        logic [63:0] exp_q[$];
        logic [63:0] pcs[2];
        int hs0, p0;
        logic [63:0] x;
        pcs[0] = 64'h100; pcs[1] = 64'h108;
        hs0 = hs_cnt; p0 = pulse_cnt;
        for (int i = 0; i < 2; i++) begin
            x = {$urandom, $urandom};
            exp_q.push_back(x);
            do_read(pcs[i], x, 2'b00, 1'b1, 0, 0, 1'b0, 1'b0,
                    a, st, rra, rrr, v, d, e, lat, to);
            x = exp_q.pop_front();
            total++;
            if (a !== ref_addr(pcs[i]) || d !== x || v !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d: addr=%h inst=%h want %h %h", i, a, d, ref_addr(pcs[i]), x);
            end
            release_ena();
        end
        total++;
        if (hs_cnt - hs0 !== 2 || pulse_cnt - p0 !== 2) begin
            bad++; $display("FAIL b2b_counts: hs=%0d pulses=%0d want 2 2", hs_cnt - hs0, pulse_cnt - p0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a; logic st, rra, rrr, v, e, to; logic [63:0] d; int lat;
        logic [63:0] pc, data; logic [1:0] resp; logic last;
        int hs0, p0, errs;
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            pc = {$urandom, $urandom}; data = {$urandom, $urandom};
            resp = 2'($urandom_range(0, 3)); last = ($urandom_range(0, 3) != 0);
            hs0 = hs_cnt; p0 = pulse_cnt;
            do_read(pc, data, resp, last, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a, st, rra, rrr, v, d, e, lat, to);
            release_ena();
            total++;
            if (to || a !== ref_addr(pc) || !st || rra || v !== 1'b1 || d !== data ||
                e !== ref_err(resp, last) || hs_cnt - hs0 !== 1 || pulse_cnt - p0 !== 1) begin
                bad++;
                $display("FAIL rand_%0d: addr=%h inst=%h err=%b hs=%0d pulses=%0d want %h %h %b 1 1",
                         i, a, d, e, hs_cnt - hs0, pulse_cnt - p0, ref_addr(pc), data, ref_err(resp, last));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_stall();
        test_error();
        test_done_hold();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
